// File: rtl/cpu_defs.sv
// Shared CPU front-end types and constants: fetch bus, commit flush flags,
// exception record and the BEV=1 reset/exception vectors.
package cpu_defs;

  typedef logic [31:0] virt_t;

  localparam virt_t      RESET_PC_DEF   = 32'hBFC0_0000;
  localparam virt_t      EX_VEC_DEF     = 32'hBFC0_0380;
  localparam virt_t      REFILL_VEC_DEF = 32'hBFC0_0200;
  localparam logic [4:0] EXCCODE_ADEL   = 5'h04;

  typedef struct packed {
    logic ex;
    logic eret;
    logic tlb_op;
    logic refill;
  } pipeline_flush_t;

  typedef struct packed {
    logic       ex;
    logic [4:0] exccode;
    virt_t      badvaddr;
  } exception_t;

  typedef struct packed {
    logic       valid;
    logic       req;
    logic       br_op;
    virt_t      pc;
    exception_t exception;
  } pfs_to_fs_bus_t;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } pfs_state_e;

endpackage

// File: rtl/pre_if_stage_npc_sel.sv
// npc_sel: fixed-priority redirect selector for the fetch PC
// (exception > eret > tlb refetch > branch-predictor redirect).
module npc_sel
  import cpu_defs::*;
#(
  parameter virt_t EX_VEC     = EX_VEC_DEF,
  parameter virt_t REFILL_VEC = REFILL_VEC_DEF
) (
  input  pipeline_flush_t pipeline_flush,
  input  virt_t           c0_epc,
  input  virt_t           tlb_refetch_pc,
  input  logic            bpu_flush,
  input  virt_t           bpu_target,
  output logic            redirect_now,
  output virt_t           target
);

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    redirect_now = 1'b1;
    target       = '0;
    if (pipeline_flush.ex) begin
      target = pipeline_flush.refill ? REFILL_VEC : EX_VEC;
    end else if (pipeline_flush.eret) begin
      target = c0_epc;
    end else if (pipeline_flush.tlb_op) begin
      target = tlb_refetch_pc;
    end else if (bpu_flush) begin
      target = bpu_target;
    end else begin
      redirect_now = 1'b0;
    end
  end

endmodule

// File: rtl/pre_if_stage.sv
// Pre-fetch stage: owns the fetch PC, drives the instruction SRAM address phase
// and hands accepted requests to IF. Optional macro: PFS_ADEL_CHECK_EN.
module pre_if_stage
  import cpu_defs::*;
#(
  parameter virt_t RESET_PC   = RESET_PC_DEF,
  parameter virt_t EX_VEC     = EX_VEC_DEF,
  parameter virt_t REFILL_VEC = REFILL_VEC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fs_allowin,
  input  logic            fs_to_pfs_valid,
  input  logic            ds_br_op,
  input  logic            bpu_flush,
  input  virt_t           bpu_target,
  input  pipeline_flush_t pipeline_flush,
  input  virt_t           c0_epc,
  input  virt_t           tlb_refetch_pc,
  output pfs_to_fs_bus_t  pfs_to_fs_bus,
  output logic            inst_req,
  output virt_t           inst_addr,
  input  logic            inst_addr_ok
);

  pfs_state_e state_q, state_d;
  virt_t      pc_q, pc_d;
  logic       addr_ok_q, addr_ok_d;
  logic       bpu_pend_q, bpu_pend_d;
  virt_t      bpu_tgt_q, bpu_tgt_d;

  exception_t exc;
  logic       accept, hold_valid, pfs_ready_go, handover;
  logic       flush_any, bpu_defer, bpu_now, pend_eff;
  virt_t      tgt_eff;
  logic       redirect_now;
  virt_t      redirect_target;

`ifdef PFS_ADEL_CHECK_EN
  always_comb begin
    exc = '0;
    if (pc_q[1:0] != 2'b00) begin
      exc.ex       = 1'b1;
      exc.exccode  = EXCCODE_ADEL;
      exc.badvaddr = pc_q;
    end
  end
  assign inst_addr = pc_q;
`else
  assign exc       = '0;
  assign inst_addr = {pc_q[31:2], 2'b00};
`endif

  // A faulting PC never reaches the SRAM; reset always shows inst_req=0.
  assign inst_req     = !reset && (state_q == ST_REQ) && !exc.ex;
  assign accept       = inst_req && inst_addr_ok;
  assign hold_valid   = (state_q == ST_HOLD) && addr_ok_q;
  assign pfs_ready_go = accept || hold_valid || exc.ex;

  assign flush_any = pipeline_flush.ex || pipeline_flush.eret || pipeline_flush.tlb_op;
  // A redirect is deferred while its delay slot is still ours to hand over.
  assign bpu_defer = bpu_flush && (bpu_pend_q || (ds_br_op && !fs_to_pfs_valid));
  assign bpu_now   = bpu_flush && !bpu_defer;
  assign pend_eff  = bpu_defer || bpu_pend_q;
  assign tgt_eff   = bpu_defer ? bpu_target : bpu_tgt_q;

  npc_sel #(
    .EX_VEC     (EX_VEC),
    .REFILL_VEC (REFILL_VEC)
  ) u_npc_sel (
    .pipeline_flush (pipeline_flush),
    .c0_epc         (c0_epc),
    .tlb_refetch_pc (tlb_refetch_pc),
    .bpu_flush      (bpu_now),
    .bpu_target     (bpu_target),
    .redirect_now   (redirect_now),
    .target         (redirect_target)
  );

  assign handover = pfs_ready_go && !redirect_now && fs_allowin;

  always_comb begin
    pfs_to_fs_bus    = '0;
    pfs_to_fs_bus.pc = pc_q;
    if (!reset) begin
      pfs_to_fs_bus.valid     = pfs_ready_go && !redirect_now;
      pfs_to_fs_bus.req       = accept;
      pfs_to_fs_bus.br_op     = ds_br_op;
      pfs_to_fs_bus.exception = exc;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_ok_d  = addr_ok_q;
    bpu_pend_d = pend_eff;
    bpu_tgt_d  = tgt_eff;
    if (redirect_now) begin
      // Anything accepted or held for the old PC is dropped; IF cancels its data.
      pc_d       = redirect_target;
      state_d    = ST_REQ;
      addr_ok_d  = 1'b0;
      bpu_pend_d = 1'b0;
    end else if (handover) begin
      pc_d       = pend_eff ? tgt_eff : pc_q + 32'd4;
      state_d    = ST_REQ;
      addr_ok_d  = 1'b0;
      bpu_pend_d = 1'b0;
    end else if (accept) begin
      state_d   = ST_HOLD;
      addr_ok_d = 1'b1;
    end
    if (flush_any) bpu_pend_d = 1'b0;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_REQ;
      pc_q       <= RESET_PC;
      addr_ok_q  <= 1'b0;
      bpu_pend_q <= 1'b0;
      bpu_tgt_q  <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_ok_q  <= addr_ok_d;
      bpu_pend_q <= bpu_pend_d;
      bpu_tgt_q  <= bpu_tgt_d;
    end
  end

endmodule

// File: tb/tb_pre_if_stage.sv
// Scoreboard bench for pre_if_stage: stimulus queues expected handovers,
// a negedge monitor pops and compares each accepted pfs_to_fs_bus entry.
module tb_pre_if_stage;
  import cpu_defs::*;

  logic            clk = 1'b0;
  logic            reset;
  logic            fs_allowin;
  logic            fs_to_pfs_valid;
  logic            ds_br_op;
  logic            bpu_flush;
  virt_t           bpu_target;
  pipeline_flush_t pipeline_flush;
  virt_t           c0_epc;
  virt_t           tlb_refetch_pc;
  pfs_to_fs_bus_t  bus;
  logic            inst_req;
  virt_t           inst_addr;
  logic            inst_addr_ok;

  pfs_to_fs_bus_t  exp_q[$];
  pfs_to_fs_bus_t  rst_exp;
  int              n_checks = 0;
  int              n_pass   = 0;

  always #5 clk = ~clk;

  pre_if_stage dut (
    .clk             (clk),
    .reset           (reset),
    .fs_allowin      (fs_allowin),
    .fs_to_pfs_valid (fs_to_pfs_valid),
    .ds_br_op        (ds_br_op),
    .bpu_flush       (bpu_flush),
    .bpu_target      (bpu_target),
    .pipeline_flush  (pipeline_flush),
    .c0_epc          (c0_epc),
    .tlb_refetch_pc  (tlb_refetch_pc),
    .pfs_to_fs_bus   (bus),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_addr_ok    (inst_addr_ok)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic pfs_to_fs_bus_t mk(input virt_t pc, input logic req, input logic br,
                                        input logic ex);
    mk       = '0;
    mk.valid = 1'b1;
    mk.req   = req;
    mk.br_op = br;
    mk.pc    = pc;
    if (ex) begin
      mk.exception.ex       = 1'b1;
      mk.exception.exccode  = 5'h04;
      mk.exception.badvaddr = pc;
    end
  endfunction

  // Monitor: every entry IF actually accepts must match the next expectation.
  always @(negedge clk) begin
    if (!reset && bus.valid && fs_allowin) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL handover_unexpected: got pc %h, expected no handover", bus.pc);
      end else begin
        check("handover", bus, exp_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    fs_allowin      = 1'b0;
    fs_to_pfs_valid = 1'b0;
    ds_br_op        = 1'b0;
    bpu_flush       = 1'b0;
    bpu_target      = '0;
    pipeline_flush  = '0;
    c0_epc          = '0;
    tlb_refetch_pc  = '0;
    inst_addr_ok    = 1'b0;
  endtask

  task automatic go(input logic aok, input logic allow);
    inst_addr_ok = aok;
    fs_allowin   = allow;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_exp    = '0;
    rst_exp.pc = 32'hBFC0_0000;
    reset      = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_inst_req", inst_req, 1'b0);
    check("rst_bus", bus, rst_exp);
    check("rst_inst_addr", inst_addr, 32'hBFC0_0000);
    next_cycle();
    reset = 1'b0;

    // Back-to-back sequential fetch.
    for (int i = 0; i < 4; i++) begin
      go(1, 1);
      exp_q.push_back(mk(32'hBFC0_0000 + 32'(i * 4), 1, 0, 0));
      @(negedge clk);
      check("seq_addr", inst_addr, 32'hBFC0_0000 + 32'(i * 4));
      check("seq_valid", bus.valid, 1'b1);
      next_cycle();
    end

    // Accepted at BFC00010 while IF is stalled for three cycles.
    go(1, 0);
    @(negedge clk);
    check("accept_req", inst_req, 1'b1);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("hold_req", inst_req, 1'b0);
      check("hold_valid", bus.valid, 1'b1);
      check("hold_pc", bus.pc, 32'hBFC0_0010);
      next_cycle();
    end
    go(0, 1);
    exp_q.push_back(mk(32'hBFC0_0010, 0, 0, 0));
    @(negedge clk);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      go(1, 1);
      exp_q.push_back(mk(32'hBFC0_0014 + 32'(i * 4), 1, 0, 0));
      @(negedge clk);
      check("after_hold_addr", inst_addr, 32'hBFC0_0014 + 32'(i * 4));
      next_cycle();
    end

    // Exception on the accept cycle at BFC00020, then refill exception.
    go(1, 1);
    pipeline_flush.ex = 1'b1;
    @(negedge clk);
    check("ex_valid", bus.valid, 1'b0);
    next_cycle();
    go(1, 1);
    exp_q.push_back(mk(32'hBFC0_0380, 1, 0, 0));
    @(negedge clk);
    check("ex_vec", inst_addr, 32'hBFC0_0380);
    next_cycle();
    go(1, 1);
    pipeline_flush.ex     = 1'b1;
    pipeline_flush.refill = 1'b1;
    @(negedge clk);
    check("refill_valid", bus.valid, 1'b0);
    next_cycle();
    go(0, 1);
    @(negedge clk);
    check("refill_vec", inst_addr, 32'hBFC0_0200);
    check("refill_req", inst_req, 1'b1);
    next_cycle();

    // TLB refetch to BFC00030, which becomes a delay slot.
    go(0, 1);
    pipeline_flush.tlb_op = 1'b1;
    tlb_refetch_pc        = 32'hBFC0_0030;
    @(negedge clk);
    check("tlb_valid", bus.valid, 1'b0);
    next_cycle();
    go(0, 1);
    bpu_flush  = 1'b1;
    bpu_target = 32'h8000_1000;
    ds_br_op   = 1'b1;
    @(negedge clk);
    check("defer_addr", inst_addr, 32'hBFC0_0030);
    next_cycle();
    go(1, 1);
    ds_br_op = 1'b1;
    exp_q.push_back(mk(32'hBFC0_0030, 1, 1, 0));
    @(negedge clk);
    next_cycle();
    go(1, 1);
    exp_q.push_back(mk(32'h8000_1000, 1, 0, 0));
    @(negedge clk);
    check("bpu_applied", inst_addr, 32'h8000_1000);
    next_cycle();

    // ERET together with a deferrable bpu_flush: ERET wins, pending cleared.
    go(1, 1);
    pipeline_flush.eret = 1'b1;
    c0_epc              = 32'h8000_2004;
    bpu_flush           = 1'b1;
    bpu_target          = 32'h1234_5678;
    ds_br_op            = 1'b1;
    @(negedge clk);
    check("eret_valid", bus.valid, 1'b0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      go(1, 1);
      exp_q.push_back(mk(32'h8000_2004 + 32'(i * 4), 1, 0, 0));
      @(negedge clk);
      check("eret_seq", inst_addr, 32'h8000_2004 + 32'(i * 4));
      next_cycle();
    end

    // Immediate bpu redirect, then PC wrap at the top of the address space.
    go(1, 1);
    bpu_flush  = 1'b1;
    bpu_target = 32'h9000_0000;
    @(negedge clk);
    check("bpu_now_valid", bus.valid, 1'b0);
    next_cycle();
    pipeline_flush.tlb_op = 1'b1;
    tlb_refetch_pc        = 32'hFFFF_FFFC;
    @(negedge clk);
    check("bpu_now_addr", inst_addr, 32'h9000_0000);
    next_cycle();
    go(1, 1);
    exp_q.push_back(mk(32'hFFFF_FFFC, 1, 0, 0));
    @(negedge clk);
    next_cycle();
    go(1, 1);
    exp_q.push_back(mk(32'h0000_0000, 1, 0, 0));
    @(negedge clk);
    check("wrap_addr", inst_addr, 32'h0000_0000);
    next_cycle();

    // ERET to a misaligned PC.
    pipeline_flush.eret = 1'b1;
    c0_epc              = 32'h8000_0002;
    @(negedge clk);
    next_cycle();
`ifdef PFS_ADEL_CHECK_EN
    go(0, 1);
    exp_q.push_back(mk(32'h8000_0002, 0, 0, 1));
    @(negedge clk);
    check("adel_req", inst_req, 1'b0);
    check("adel_valid", bus.valid, 1'b1);
    next_cycle();
`else
    go(1, 1);
    exp_q.push_back(mk(32'h8000_0002, 1, 0, 0));
    @(negedge clk);
    check("align_addr", inst_addr, 32'h8000_0000);
    check("align_req", inst_req, 1'b1);
    next_cycle();
`endif

    // Reset arriving with an accepted request outstanding.
    go(1, 0);
    @(negedge clk);
    next_cycle();
    reset    = 1'b1;
    ds_br_op = 1'b1;
    @(negedge clk);
    check("midrst_req", inst_req, 1'b0);
    check("midrst_valid", bus.valid, 1'b0);
    next_cycle();
    ds_br_op = 1'b1;
    @(negedge clk);
    check("midrst_bus", bus, rst_exp);
    check("midrst_addr", inst_addr, 32'hBFC0_0000);
    next_cycle();
    reset = 1'b0;
    go(1, 1);
    exp_q.push_back(mk(32'hBFC0_0000, 1, 0, 0));
    @(negedge clk);
    check("postrst_req", inst_req, 1'b1);
    next_cycle();

    next_cycle();
    check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
